// File: rtl/sprite_capture_if.sv
// Video-stream, capture-control and readback signals shared between the
// snapshot block and whatever drives it.
interface sprite_capture_if #(
    parameter int PIXEL_BITS = 12,
    parameter int ADDR_BITS  = 16
);
    logic                  arm_in;
    logic [10:0]           x_in;
    logic [9:0]            y_in;
    logic [10:0]           hcount_in;
    logic [9:0]            vcount_in;
    logic [PIXEL_BITS-1:0] pixel_in;
    logic [ADDR_BITS-1:0]  rd_addr_in;
    logic [PIXEL_BITS-1:0] rd_data_out;
    logic                  busy_out;
    logic                  done_out;
    logic [ADDR_BITS:0]    count_out;

    modport master (
        output arm_in, x_in, y_in, hcount_in, vcount_in, pixel_in, rd_addr_in,
        input  rd_data_out, busy_out, done_out, count_out
    );

    modport slave (
        input  arm_in, x_in, y_in, hcount_in, vcount_in, pixel_in, rd_addr_in,
        output rd_data_out, busy_out, done_out, count_out
    );
endinterface

// File: rtl/sprite_capture.sv
// Snapshots a WIDTH x HEIGHT window of the live hcount/vcount/pixel stream
// into block RAM. Arm, wait for a frame start, capture one frame's worth of
// window pixels, then hold DONE until re-armed. Readback is a 2-cycle
// registered port that works in every state.
module sprite_capture #(
    parameter int WIDTH      = 256,
    parameter int HEIGHT     = 256,
    parameter int PIXEL_BITS = 12
) (
    input  logic            pixel_clk_in,
    input  logic            rst_in,
    sprite_capture_if.slave bus
);
    localparam int ADDR_BITS = $clog2(WIDTH * HEIGHT);
    localparam int DEPTH     = WIDTH * HEIGHT;
    localparam int X_SHIFT   = $clog2(WIDTH);

    // Window bounds are one bit wider than the coordinates so x+WIDTH never wraps.
    localparam logic [11:0]          WIDTH_12  = 12'(WIDTH);
    localparam logic [10:0]          HEIGHT_11 = 11'(HEIGHT);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS:0]   COUNT_ONE = (ADDR_BITS + 1)'(1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURING, DONE} state_t;

    state_t                state;
    logic [10:0]           x_q;
    logic [9:0]            y_q;
    logic [ADDR_BITS:0]    count_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_BITS-1:0]  rd_addr_q;
    logic [PIXEL_BITS-1:0] rd_data_q;
    logic [PIXEL_BITS-1:0] mem [DEPTH];

    logic                  frame_start;
    logic                  in_window;
    logic                  wr_en;
    logic                  wr_last;
    logic [11:0]           x_end;
    logic [10:0]           y_end;
    logic [10:0]           dx;
    logic [9:0]            dy;
    logic [ADDR_BITS-1:0]  wr_addr;

    // Window test and write address for the pixel presented this cycle.
    always_comb begin
        frame_start = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
        x_end       = {1'b0, x_q} + WIDTH_12;
        y_end       = {1'b0, y_q} + HEIGHT_11;
        in_window   = (bus.hcount_in >= x_q) && ({1'b0, bus.hcount_in} < x_end) &&
                      (bus.vcount_in >= y_q) && ({1'b0, bus.vcount_in} < y_end);
        dx          = bus.hcount_in - x_q;
        dy          = bus.vcount_in - y_q;
        // WIDTH is a power of two, so row*WIDTH + col is a shift and OR;
        // dx < WIDTH whenever the pixel is inside the window.
        wr_addr     = (ADDR_BITS'(dy) << X_SHIFT) | ADDR_BITS'(dx);
        wr_en       = 1'b0;
        if (!rst_in && in_window) begin
            case (state)
                ARMED:     wr_en = frame_start;
                CAPTURING: wr_en = !frame_start;
                default:   wr_en = 1'b0;
            endcase
        end
        wr_last = wr_en && (wr_addr == LAST_ADDR);
    end

    // Capture control FSM with registered busy/done flags and pixel counter.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state   <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                count_q <= count_q + COUNT_ONE;
            end
            case (state)
                IDLE, DONE: begin
                    if (bus.arm_in) begin
                        state   <= ARMED;
                        x_q     <= bus.x_in;
                        y_q     <= bus.y_in;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ARMED: begin
                    // Only start on a frame boundary so the snapshot is never a partial frame.
                    if (frame_start) begin
                        if (wr_last) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state  <= CAPTURING;
                        end
                    end
                end
                CAPTURING: begin
                    // A second frame start means the window runs off the frame: stop with a partial count.
                    if (frame_start || wr_last) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Pixel store; contents survive reset.
    always_ff @(posedge pixel_clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.pixel_in;
        end
    end

    // Readback: registered address, then registered RAM output (read-first).
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            rd_addr_q <= bus.rd_addr_in;
            rd_data_q <= mem[rd_addr_q];
        end
    end

    assign bus.rd_data_out = rd_data_q;
    assign bus.busy_out    = busy_q;
    assign bus.done_out    = done_q;
    assign bus.count_out   = count_q;
endmodule

// File: tb/tb_sprite_capture.sv
// Bench for sprite_capture using a reduced 16x8 window on a 48x30 frame so
// several complete frames fit in a short run.
`timescale 1ns/1ps
module tb_sprite_capture;
    localparam int W     = 16;
    localparam int H     = 8;
    localparam int PB    = 12;
    localparam int AB    = 7;
    localparam int DEPTH = W * H;
    localparam int H_TOT = 48;
    localparam int V_TOT = 30;
    localparam int FRAME = H_TOT * V_TOT;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_CAPT  = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sprite_capture_if #(.PIXEL_BITS(PB), .ADDR_BITS(AB)) bus ();

    sprite_capture #(.WIDTH(W), .HEIGHT(H), .PIXEL_BITS(PB)) dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .bus          (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus raster position and per-frame pixel scramble.
    int          h = 0;
    int          v = 0;
    logic [PB-1:0] salt = '0;
    bit          rand_rd = 1'b1;

    // Reference model state.
    int m_mode, m_x, m_y, m_count, m_ra, m_rd;
    int m_mem [DEPTH];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)", tag, got, exp, h, v, $time);
        end
    endtask

    function automatic logic [PB-1:0] pat(input int ph, input int pv, input logic [PB-1:0] s);
        return {6'(ph), 6'(pv)} ^ s;
    endfunction

    task automatic drive_pixel();
        bus.hcount_in = 11'(h);
        bus.vcount_in = 10'(v);
        bus.pixel_in  = pat(h, v, salt);
    endtask

    // Apply the capture rules to the inputs about to be clocked in.
    task automatic model_edge();
        int  a;
        bit  fs, inw, wr;
        if (rst) begin
            m_mode = M_IDLE; m_x = 0; m_y = 0; m_count = 0; m_ra = 0; m_rd = 0;
            return;
        end
        m_rd = m_mem[m_ra];
        m_ra = int'(bus.rd_addr_in);
        fs   = (h == 0) && (v == 0);
        inw  = (h >= m_x) && (h < m_x + W) && (v >= m_y) && (v < m_y + H);
        wr   = 1'b0;
        case (m_mode)
            M_IDLE, M_DONE: if (bus.arm_in) begin
                m_mode = M_ARMED; m_x = int'(bus.x_in); m_y = int'(bus.y_in); m_count = 0;
            end
            M_ARMED: if (fs) begin m_mode = M_CAPT; wr = inw; end
            M_CAPT:  if (fs) m_mode = M_DONE; else wr = inw;
            default: ;
        endcase
        if (wr) begin
            a = (v - m_y) * W + (h - m_x);
            m_mem[a] = int'(bus.pixel_in);
            m_count++;
            if (a == DEPTH - 1) m_mode = M_DONE;
        end
    endtask

    // One clock: model, edge, compare, then advance the stimulus.
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_eq("busy", bus.busy_out, (m_mode == M_ARMED) || (m_mode == M_CAPT));
        check_eq("done", bus.done_out, m_mode == M_DONE);
        check_eq("count", bus.count_out, m_count);
        if (m_rd >= 0) check_eq("rd_data", bus.rd_data_out, m_rd);
        bus.arm_in = 1'b0;
        rst = 1'b0;
        h++;
        if (h == H_TOT) begin
            h = 0;
            v++;
            if (v == V_TOT) begin
                v = 0;
                salt = salt ^ PB'($urandom_range(1, 4095));
            end
        end
        drive_pixel();
        if (rand_rd) bus.rd_addr_in = AB'($urandom);
    endtask

    task automatic wait_at(input int th, input int tv);
        int n = 0;
        while (!(h == th && v == tv) && n <= FRAME) begin
            cyc();
            n++;
        end
        if (!(h == th && v == tv)) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_at: position %0d,%0d required %0d,%0d", h, v, th, tv);
        end
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n = 0;
        while (!bus.done_out && n < max_cyc) begin
            cyc();
            n++;
        end
        check_eq(tag, bus.done_out, 1);
    endtask

    task automatic arm(input int ax, input int ay);
        bus.arm_in = 1'b1;
        bus.x_in   = 11'(ax);
        bus.y_in   = 10'(ay);
    endtask

    task automatic read_back(input int addr, input logic [PB-1:0] exp, input string tag);
        rand_rd = 1'b0;
        bus.rd_addr_in = AB'(addr);
        cyc();
        cyc();
        check_eq(tag, bus.rd_data_out, exp);
        rand_rd = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PB-1:0] old_salt;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = -1;
        m_mode = M_IDLE; m_x = 0; m_y = 0; m_count = 0; m_ra = 0; m_rd = -1;
        rst = 1'b1;
        bus.arm_in = 1'b0;
        bus.x_in = '0;
        bus.y_in = '0;
        bus.rd_addr_in = '0;
        drive_pixel();

        // Reset for two cycles with junk on the inputs.
        rst = 1'b1; arm(int'($urandom_range(0, 47)), int'($urandom_range(0, 29))); cyc();
        rst = 1'b1; arm(int'($urandom_range(0, 47)), int'($urandom_range(0, 29))); cyc();
        check_eq("rst_busy", bus.busy_out, 0);
        check_eq("rst_done", bus.done_out, 0);
        check_eq("rst_count", bus.count_out, 0);
        check_eq("rst_rd", bus.rd_data_out, 0);

        // Full capture armed just before a frame start.
        wait_at(0, V_TOT - 1);
        arm(16, 8);
        cyc();
        check_eq("arm_busy", bus.busy_out, 1);
        wait_at(31, 15);
        check_eq("pre_done", bus.done_out, 0);
        cyc();
        check_eq("full_done", bus.done_out, 1);
        check_eq("full_count", bus.count_out, DEPTH);
        read_back(2 * W + 3, pat(19, 10, salt), "full_rd");
        old_salt = salt;

        // Re-arm from DONE mid-frame: flags clear next edge, nothing written until frame start.
        arm(16, 8);
        cyc();
        check_eq("rearm_done", bus.done_out, 0);
        check_eq("rearm_count", bus.count_out, 0);
        check_eq("rearm_busy", bus.busy_out, 1);
        wait_at(0, 0);
        check_eq("midarm_count", bus.count_out, 0);
        // Arm during capture must be ignored.
        wait_at(20, 9);
        arm(0, 0);
        cyc();
        wait_done(2 * FRAME, "midarm_done");
        check_eq("midarm_total", bus.count_out, DEPTH);
        read_back(2 * W + 3, pat(19, 10, salt), "midarm_newframe");
        check_eq("midarm_salt_changed", (pat(19, 10, salt) != pat(19, 10, old_salt)), 1);
        read_back(0, pat(16, 8, salt), "ignored_arm_addr0");

        // Clipped window: 8 columns x 5 lines fit in the frame.
        arm(40, 25);
        cyc();
        wait_done(3 * FRAME, "clip_done");
        check_eq("clip_count", bus.count_out, 8 * 5);
        check_eq("clip_at_frame_start", (h == 1 && v == 0), 1);

        // Reset in the middle of a capture, then a clean re-capture.
        arm(16, 8);
        cyc();
        wait_at(0, 0);
        wait_at(20, 12);
        rst = 1'b1;
        cyc();
        check_eq("midrst_busy", bus.busy_out, 0);
        check_eq("midrst_count", bus.count_out, 0);
        check_eq("midrst_done", bus.done_out, 0);
        arm(16, 8);
        cyc();
        wait_done(3 * FRAME, "recap_done");
        check_eq("recap_count", bus.count_out, DEPTH);

        // Window at the origin: first pixel is written on the arming frame start.
        arm(0, 0);
        cyc();
        wait_done(3 * FRAME, "origin_done");
        check_eq("origin_count", bus.count_out, DEPTH);
        read_back(0, pat(0, 0, salt), "origin_rd0");

        // Random arms, windows and occasional resets against the model.
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 199) == 0) arm(int'($urandom_range(0, 50)), int'($urandom_range(0, 32)));
            if ($urandom_range(0, 2999) == 0) rst = 1'b1;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_capture.md
Name: sprite_capture

Overview:
- Captures a WIDTH x HEIGHT rectangular window of a live video pixel stream into on-chip BRAM.
- The stream is the same hcount/vcount/pixel bus that the sprite renderers consume, so this is the write side of the sprite image path: it produces sprite-sized images instead of reading them.
- Captured data is read back through a synchronous read port, by a Manta memory core or by a renderer.
- Arm/capture/done control gives single-frame snapshots.

Parameters:
- WIDTH, 256, window width in pixels; power of two.
- HEIGHT, 256, window height in lines.
- PIXEL_BITS, 12, pixel width (4:4:4 RGB).
- ADDR_BITS is derived as $clog2(WIDTH*HEIGHT) = 16; it is not overridable.

Ports:
- pixel_clk_in  input  1  pixel clock; all logic runs on its rising edge.
- rst_in  input  1  synchronous, active-high reset.
- arm_in  input  1  single-cycle pulse; requests a capture.
- x_in  input  11  window left edge; sampled on accepted arm.
- y_in  input  10  window top edge; sampled on accepted arm.
- hcount_in  input  11  current pixel column.
- vcount_in  input  10  current pixel row.
- pixel_in  input  PIXEL_BITS  pixel at (hcount_in, vcount_in), valid in the same cycle.
- rd_addr_in  input  ADDR_BITS  readback address.
- rd_data_out  output  PIXEL_BITS  readback data.
- busy_out  output  1  high in ARMED or CAPTURING.
- done_out  output  1  high in DONE.
- count_out  output  ADDR_BITS+1  number of pixels written in the current/last capture.

Behaviour:
- Reset state: IDLE, busy_out=0, done_out=0, count_out=0, rd_data_out=0, latched x/y=0.
- BRAM contents are not cleared by reset.
- Reset takes effect on the next edge from any state, including mid-capture. An in-flight write on that edge is suppressed.
- FSM states: IDLE, ARMED, CAPTURING, DONE.
- IDLE: arm_in=1 -> ARMED. On that edge latch x_in/y_in and clear count_out to 0.
- ARMED: waits for frame start, defined as hcount_in==0 && vcount_in==0. This avoids partial frames. At frame start -> CAPTURING; that same cycle's pixel is written if it lies in the window.
- CAPTURING: a pixel is in the window when x <= hcount_in < x+WIDTH and y <= vcount_in < y+HEIGHT. Window bounds are computed 12-bit (hcount) and 11-bit (vcount), so x+WIDTH never wraps.
  - In-window pixel: write pixel_in to addr = (vcount_in-y)*WIDTH + (hcount_in-x), computed as a shift/concat because WIDTH is a power of two, and increment count_out.
  - Write to addr WIDTH*HEIGHT-1 -> DONE on the following edge. count_out = WIDTH*HEIGHT (65536 at defaults).
  - If frame start recurs before completion (window extends past the frame), -> DONE without writing that cycle. count_out holds the partial count.
- DONE: done_out=1 and count_out are held. arm_in=1 -> ARMED; clears done_out and count_out and re-latches x/y on the same edge.
- arm_in in ARMED or CAPTURING is ignored; it does not restart or re-latch.
- busy_out and done_out are registered and reflect the current state; they are never both high.
- Read port:
  - Latency is 2 cycles: rd_addr_in is registered, then BRAM output is registered.
  - It operates in every state.
  - Reading the address being written on the same edge returns the old contents (read-first).
  - Out-of-range rd_addr_in is impossible by width.
- The write path adds no pipeline delay: the pixel is written on the edge where its hcount/vcount is presented.

Test Plan:
- Reset: hold rst_in for 2 cycles with arbitrary inputs -> busy_out=0, done_out=0, count_out=0, rd_data_out=0.
- Full capture: arm with x_in=256, y_in=256; sweep frames of 1344x806 with pixel_in={hcount[5:0],vcount[5:0]} -> busy_out rises the next cycle; done_out rises one cycle after (hcount 511, vcount 511); count_out=65536; reading addr 10*256+3 returns 12'h0CA after 2 cycles.
- Mid-frame arm: arm at vcount=300 -> no writes and count_out stays 0 until the next hcount=0/vcount=0; the captured data then matches the next frame only (change the pixel pattern between frames to prove it).
- Clipped window: x_in=900, y_in=700, 806-line frame -> DONE at the next frame start; count_out=106*256=27136; done_out=1.
- Reset mid-capture: assert rst_in at vcount=400 -> IDLE, count_out=0, busy_out=0. Re-arming with the same x/y then completes normally with count_out=65536.
- Re-arm rules: arm pulse during CAPTURING with x_in=0 -> ignored (addr 0 still holds the pixel from (256,256)). Arm pulse in DONE -> done_out=0 and count_out=0 on the next edge, busy_out=1.
